// File: rtl/poly_fir_pkg.sv
// Shared defaults, types and address helper for the 1/9 polyphase decimator
// coefficient path.
package poly_fir_pkg;

    localparam int DEF_DECIMATION_FACTOR = 9;
    localparam int DEF_TAP_LEN           = 63;
    localparam int DEF_COEF_WIDTH        = 16;

    typedef logic signed [DEF_COEF_WIDTH-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED,
        COPY
    } cfg_state_e;

    // Branch i, sub-tap j of the polyphase split maps to prototype tap j*D+i.
    function automatic int unsigned poly_addr(input int unsigned i, input int unsigned j);
        return j * DEF_DECIMATION_FACTOR + i;
    endfunction

endpackage

// File: rtl/poly_coef_bank_ram.sv
// Two coefficient banks with one shared write port, a registered read per bank,
// and an internal bank-to-bank copy path used for shadow re-sync.
module poly_coef_bank_ram #(
    parameter  int TAP_LEN    = 63,
    parameter  int COEF_WIDTH = 16,
    localparam int AW         = $clog2(TAP_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_we,
    input  logic                         i_wbank,
    input  logic                         i_copy,
    input  logic                         i_mirror,
    input  logic [AW-1:0]                i_waddr,
    input  logic signed [COEF_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]                i_raddr,
    output logic signed [COEF_WIDTH-1:0] o_rdata0,
    output logic signed [COEF_WIDTH-1:0] o_rdata1
);

    logic signed [COEF_WIDTH-1:0] r_bank0 [0:TAP_LEN-1];
    logic signed [COEF_WIDTH-1:0] r_bank1 [0:TAP_LEN-1];
    logic signed [COEF_WIDTH-1:0] w_src;
    logic signed [COEF_WIDTH-1:0] w_wdata;
    logic [AW-1:0]                w_maddr;

    // In copy mode the data comes from the same address of the other bank.
    assign w_src   = i_wbank ? r_bank0[i_waddr] : r_bank1[i_waddr];
    assign w_wdata = i_copy ? w_src : i_wdata;
    assign w_maddr = AW'(TAP_LEN - 1) - i_waddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAP_LEN; k++) begin
                r_bank0[k] <= '0;
                r_bank1[k] <= '0;
            end
            o_rdata0 <= '0;
            o_rdata1 <= '0;
        end else begin
            if (i_we) begin
                if (i_wbank) begin
                    r_bank1[i_waddr] <= w_wdata;
                    if (i_mirror) r_bank1[w_maddr] <= w_wdata;
                end else begin
                    r_bank0[i_waddr] <= w_wdata;
                    if (i_mirror) r_bank0[w_maddr] <= w_wdata;
                end
            end
            o_rdata0 <= r_bank0[i_raddr];
            o_rdata1 <= r_bank1[i_raddr];
        end
    end

endmodule

// File: rtl/poly_coef_bank_ctrl.sv
// Double-buffered coefficient controller: shadow load, frame-aligned swap, shadow re-sync.
// Optional feature macro: POLY_COEF_SYM_EN (linear-phase mirrored writes on the lower half).
module poly_coef_bank_ctrl
    import poly_fir_pkg::*;
#(
    parameter  int DECIMATION_FACTOR = DEF_DECIMATION_FACTOR,
    parameter  int TAP_LEN           = DEF_TAP_LEN,
    parameter  int COEF_WIDTH        = DEF_COEF_WIDTH,
    localparam int SUB_TAP_LEN       = TAP_LEN / DECIMATION_FACTOR,
    localparam int AW                = $clog2(TAP_LEN),
    localparam int PW                = $clog2(DECIMATION_FACTOR),
    localparam int TW                = $clog2(SUB_TAP_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [AW-1:0]                cfg_addr,
    input  logic signed [COEF_WIDTH-1:0] cfg_data,
    input  logic                         cfg_last,
    input  logic                         frame_start,
    input  logic [PW-1:0]                rd_phase,
    input  logic [TW-1:0]                rd_tap,
    output logic signed [COEF_WIDTH-1:0] rd_data,
    output logic                         active_bank,
    output logic                         swap_done,
    output logic                         busy,
    output logic                         err_addr
);

    cfg_state_e r_state;
    cfg_state_e w_state_nxt;

    logic          r_active_bank;
    logic          r_swap_done;
    logic          r_err_addr;
    logic          r_rd_ok;
    logic          r_rd_sel;
    logic [AW-1:0] r_copy_cnt;

    logic          w_accept;
    logic          w_addr_ok;
    logic          w_mirror;
    logic          w_swap;
    logic          w_copy;
    logic          w_copy_last;
    logic          w_rd_ok;
    logic [AW-1:0] w_raddr;
    logic signed [COEF_WIDTH-1:0] w_rdata0;
    logic signed [COEF_WIDTH-1:0] w_rdata1;

`ifdef POLY_COEF_SYM_EN
    assign w_addr_ok = (cfg_addr <= AW'((TAP_LEN - 1) / 2));
    assign w_mirror  = 1'b1;
`else
    assign w_addr_ok = (cfg_addr < AW'(TAP_LEN));
    assign w_mirror  = 1'b0;
`endif

    assign w_accept    = cfg_valid & cfg_ready;
    assign w_copy      = (r_state == COPY);
    assign w_swap      = (r_state == ARMED) & frame_start;
    assign w_copy_last = (r_copy_cnt == AW'(TAP_LEN - 1));
    assign w_rd_ok     = (32'(rd_phase) < DECIMATION_FACTOR) && (32'(rd_tap) < SUB_TAP_LEN);
    assign w_raddr     = w_rd_ok ? AW'(poly_addr(32'(rd_phase), 32'(rd_tap))) : '0;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = cfg_last ? ARMED : LOAD;
            LOAD:  if (w_accept && cfg_last) w_state_nxt = ARMED;
            ARMED: if (frame_start) w_state_nxt = COPY;
            COPY:  if (w_copy_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == IDLE) || (r_state == LOAD);
        busy      = (r_state != IDLE);
    end

    // Read bank select is captured with the address, so a read issued on the
    // swap edge still sees the outgoing bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_bank <= 1'b0;
            r_swap_done   <= 1'b0;
            r_err_addr    <= 1'b0;
            r_copy_cnt    <= '0;
            r_rd_ok       <= 1'b0;
            r_rd_sel      <= 1'b0;
        end else begin
            r_active_bank <= r_active_bank ^ w_swap;
            r_swap_done   <= w_swap;
            r_err_addr    <= w_accept & ~w_addr_ok;
            r_copy_cnt    <= w_copy ? r_copy_cnt + AW'(1) : '0;
            r_rd_ok       <= w_rd_ok;
            r_rd_sel      <= r_active_bank;
        end
    end

    poly_coef_bank_ram #(
        .TAP_LEN    (TAP_LEN),
        .COEF_WIDTH (COEF_WIDTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_we     ((w_accept & w_addr_ok) | w_copy),
        .i_wbank  (~r_active_bank),
        .i_copy   (w_copy),
        .i_mirror (w_mirror & ~w_copy),
        .i_waddr  (w_copy ? r_copy_cnt : cfg_addr),
        .i_wdata  (cfg_data),
        .i_raddr  (w_raddr),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    assign rd_data     = r_rd_ok ? (r_rd_sel ? w_rdata1 : w_rdata0) : '0;
    assign active_bank = r_active_bank;
    assign swap_done   = r_swap_done;
    assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_poly_coef_bank_ctrl.sv
// Randomized + directed bench for poly_coef_bank_ctrl against a bank-level
// reference model (copy modelled as an instant bank duplicate plus a busy window).
module tb_poly_coef_bank_ctrl;

    localparam int D   = 9;
    localparam int N   = 63;
    localparam int SUB = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [5:0]         cfg_addr;
    logic signed [15:0] cfg_data;
    logic               cfg_last;
    logic               frame_start;
    logic [3:0]         rd_phase;
    logic [2:0]         rd_tap;
    logic signed [15:0] rd_data;
    logic               active_bank;
    logic               swap_done;
    logic               busy;
    logic               err_addr;

    poly_coef_bank_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
        .frame_start (frame_start),
        .rd_phase    (rd_phase),
        .rd_tap      (rd_tap),
        .rd_data     (rd_data),
        .active_bank (active_bank),
        .swap_done   (swap_done),
        .busy        (busy),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: two banks, which one is active, pending commit, load
    // in progress, and the remaining cycles of the post-swap re-sync window.
    int mb [2][N];
    int m_act;
    bit m_load;
    bit m_armed;
    int m_block;
    int e_rd;
    bit e_sd;
    bit e_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit addr_legal(input int a);
`ifdef POLY_COEF_SYM_EN
        return a <= (N - 1) / 2;
`else
        return a < N;
`endif
    endfunction

    task automatic tick();
        bit i_rst, i_fs, i_last, acc, ready;
        int a, d, rdv;
        i_rst  = rst;
        i_fs   = frame_start;
        i_last = cfg_last;
        a      = int'(cfg_addr);
        d      = int'(cfg_data);
        ready  = !m_armed && (m_block == 0);
        acc    = cfg_valid && ready;
        rdv    = (rd_phase < D && rd_tap < SUB) ? mb[m_act][int'(rd_tap) * D + int'(rd_phase)] : 0;
        @(posedge clk);
        if (i_rst) begin
            foreach (mb[b, k]) mb[b][k] = 0;
            m_act = 0; m_load = 0; m_armed = 0; m_block = 0;
            e_rd = 0; e_sd = 0; e_err = 0;
        end else begin
            e_rd  = rdv;
            e_err = acc && !addr_legal(a);
            e_sd  = m_armed && i_fs;
            if (m_armed && i_fs) begin
                m_act   = 1 - m_act;
                for (int k = 0; k < N; k++) mb[1 - m_act][k] = mb[m_act][k];
                m_armed = 0;
                m_block = N;
            end else if (m_block > 0) begin
                m_block--;
            end
            if (acc) begin
                if (addr_legal(a)) begin
                    mb[1 - m_act][a] = d;
`ifdef POLY_COEF_SYM_EN
                    mb[1 - m_act][N - 1 - a] = d;
`endif
                end
                if (i_last) begin
                    m_armed = 1; m_load = 0;
                end else begin
                    m_load = 1;
                end
            end
        end
        #1;
        chk("rd_data", int'(rd_data), e_rd);
        chk("cfg_ready", int'(cfg_ready), int'(!m_armed && m_block == 0));
        chk("busy", int'(busy), int'(m_load || m_armed || m_block > 0));
        chk("active_bank", int'(active_bank), m_act);
        chk("swap_done", int'(swap_done), int'(e_sd));
        chk("err_addr", int'(err_addr), int'(e_err));
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; cfg_last = 0; frame_start = 0; rst = 0;
    endtask

    task automatic wr(input int a, input int d, input bit last);
        cfg_valid = 1; cfg_addr = 6'(a); cfg_data = 16'(d); cfg_last = last;
        tick();
        cfg_valid = 0; cfg_last = 0;
    endtask

    task automatic rd(input int i, input int j);
        rd_phase = 4'(i); rd_tap = 3'(j);
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin n++; tick(); end
        chk("wait_idle", int'(busy), 0);
    endtask

    task automatic swap_now();
        frame_start = 1; tick(); frame_start = 0;
    endtask

    initial begin
        int n;
        cfg_addr = 0; cfg_data = 0; rd_phase = 0; rd_tap = 0;
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;

        // 1. post-reset
        rd(4, 5);
        chk("rst_rd", int'(rd_data), 0);
        chk("rst_bank", int'(active_bank), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);

        // 2. full load and swap
        for (int k = 0; k < N; k++) wr(k, 100 + k, k == N - 1);
        repeat (4) tick();
        swap_now();
        chk("t2_swap_done", int'(swap_done), 1);
        chk("t2_bank", int'(active_bank), 1);
        rd_phase = 2; rd_tap = 3;
        n = 0;
        while (!cfg_ready && n < 200) begin n++; tick(); end
        chk("t2_copy_len", n, N);
        chk("t2_rd_2_3", int'(rd_data), 129);
        chk("t2_idle", int'(busy), 0);

        // 3. partial update keeps the other taps
        wr(10, -5, 1);
        swap_now();
        wait_idle();
        rd(1, 1);
        chk("t3_rd_1_1", int'(rd_data), -5);
        rd(2, 3);
        chk("t3_rd_2_3", int'(rd_data), 129);

        // 4. read on the swap edge sees old bank; coincident last+frame_start defers
        wr(10, 7, 1);
        rd_phase = 1; rd_tap = 1;
        swap_now();
        chk("t4_rd_old", int'(rd_data), -5);
        tick();
        chk("t4_rd_new", int'(rd_data), 7);
        wait_idle();
        wr(0, 1, 0);
        cfg_valid = 1; cfg_addr = 1; cfg_data = 2; cfg_last = 1; frame_start = 1;
        tick();
        idle_inputs();
        chk("t4_no_swap", int'(swap_done), 0);
        repeat (3) tick();
        swap_now();
        chk("t4_second_fs", int'(swap_done), 1);
        wait_idle();

        // 5. illegal address and abort
        wr(63, 999, 1);
        chk("t5_err", int'(err_addr), 1);
        tick();
        chk("t5_err_pulse", int'(err_addr), 0);
        swap_now();
        wait_idle();
        rd(1, 1);
        chk("t5_unchanged", int'(rd_data), 7);
        wr(5, 55, 1);
        rst = 1; tick(); rst = 0;
        swap_now();
        chk("t5_abort_swap", int'(swap_done), 0);
        rd(2, 3);
        chk("t5_zero", int'(rd_data), 0);

`ifdef POLY_COEF_SYM_EN
        // 6. mirrored writes
        wr(3, 77, 1);
        swap_now();
        wait_idle();
        rd(5, 6);
        chk("t6_mirror", int'(rd_data), 77);
        wr(40, 1, 1);
        chk("t6_err", int'(err_addr), 1);
        swap_now();
        wait_idle();
`endif

        // random phase
        for (int c = 0; c < 4000; c++) begin
            cfg_valid   = ($urandom_range(0, 2) != 0);
            cfg_addr    = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, N - 1));
            cfg_data    = 16'($urandom);
            cfg_last    = ($urandom_range(0, 9) == 0);
            frame_start = ($urandom_range(0, 19) == 0);
            rd_phase    = 4'($urandom_range(0, 10));
            rd_tap      = 3'($urandom_range(0, 7));
            rst         = ($urandom_range(0, 999) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
